// File: rtl/prog_loader_if.sv
// Byte-stream input, program-memory write port and status flags of the
// program loader, bundled as one interface.
//   rx_data/rx_valid/rx_ready : framed byte stream from the host receiver
//   wr_en/wr_addr/wr_data     : program RAM write port
//   busy/done/err             : load status (busy holds the CPU in reset)
// master = host/memory side, slave = the loader itself.
interface prog_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, wr_en, wr_addr, wr_data, busy, done, err
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, wr_en, wr_addr, wr_data, busy, done, err
   );
endinterface

// File: rtl/prog_loader.sv
// Program-memory loader: parses SYNC, LEN, payload, CSUM frames from a
// valid/ready byte stream, writes the payload to program RAM from address 0
// and verifies the payload checksum.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : prog_loader_if slave (rx byte stream in, RAM write port and
//         busy/done/err status out, all registered)
module prog_loader #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DEPTH   = 256,
   parameter logic [7:0]  SYNC    = 8'hA5,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic          clk,
   input  logic          rst,
   prog_loader_if.slave  bus
);

   // Index is one bit wider than the address so a full 2^ADDR_W frame counts exactly.
   localparam int unsigned IDX_W = ADDR_W + 1;
   localparam int unsigned CMP_W = (IDX_W > 9) ? IDX_W : 9;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM
   } state_t;

   state_t            state;
   logic [8:0]        len_q;
   logic [IDX_W-1:0]  idx_q;
   logic [7:0]        sum_q;
   logic [15:0]       idle_q;

   logic              accept;
   logic [8:0]        len_n;
   logic              len_ovf;
   logic              last_byte;
   logic              tmo_hit;

   // Handshake, length decode and inter-byte timeout detection.
   always_comb begin
      accept    = bus.rx_valid & bus.rx_ready;
      len_n     = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
      len_ovf   = 32'(len_n) > DEPTH;
      last_byte = (CMP_W'(idx_q) + CMP_W'(1)) == CMP_W'(len_q);
      // An accepted byte in the same cycle always beats the timeout.
      tmo_hit   = (TIMEOUT != 16'd0) && (state != S_IDLE) && !accept &&
                  ((17'(idle_q) + 17'd1) == 17'(TIMEOUT));
   end

   // Frame FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         len_q        <= '0;
         idx_q        <= '0;
         sum_q        <= '0;
         idle_q       <= '0;
         bus.rx_ready <= 1'b0;
         bus.wr_en    <= 1'b0;
         bus.wr_addr  <= '0;
         bus.wr_data  <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         bus.rx_ready <= 1'b1;
         bus.wr_en    <= 1'b0;
         bus.done     <= 1'b0;

         if ((state == S_IDLE) || accept || tmo_hit || (TIMEOUT == 16'd0)) begin
            idle_q <= '0;
         end else begin
            idle_q <= idle_q + 16'd1;
         end

         if (tmo_hit) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
         end else if (accept) begin
            case (state)
               S_IDLE: begin
                  // Anything other than SYNC is line noise and is dropped.
                  if (bus.rx_data == SYNC) begin
                     bus.err  <= 1'b0;
                     bus.busy <= 1'b1;
                     state    <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (len_ovf) begin
                     bus.err  <= 1'b1;
                     bus.busy <= 1'b0;
                     state    <= S_IDLE;
                  end else begin
                     len_q <= len_n;
                     idx_q <= '0;
                     sum_q <= '0;
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  bus.wr_en   <= 1'b1;
                  bus.wr_addr <= idx_q[ADDR_W-1:0];
                  bus.wr_data <= bus.rx_data;
                  sum_q       <= sum_q + bus.rx_data;
                  idx_q       <= idx_q + IDX_W'(1);
                  if (last_byte) begin
                     state <= S_CSUM;
                  end
               end
               S_CSUM: begin
                  // Memory is left as written even on a bad checksum.
                  bus.busy <= 1'b0;
                  state    <= S_IDLE;
                  if (bus.rx_data == sum_q) begin
                     bus.done <= 1'b1;
                  end else begin
                     bus.err <= 1'b1;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances share one byte stream.
//   a : ADDR_W=8, DEPTH=256, TIMEOUT=8
//   b : ADDR_W=4, DEPTH=16,  TIMEOUT=0 (disabled)
// A frame-level reference model predicts every output each cycle.
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rxd = 8'd0;
   logic       rxv = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prog_loader_if #(.ADDR_W(8)) ifa ();
   prog_loader_if #(.ADDR_W(4)) ifb ();

   assign ifa.rx_data  = rxd;
   assign ifa.rx_valid = rxv;
   assign ifb.rx_data  = rxd;
   assign ifb.rx_valid = rxv;

   prog_loader #(.ADDR_W(8), .DEPTH(256), .SYNC(8'hA5), .TIMEOUT(16'd8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   prog_loader #(.ADDR_W(4), .DEPTH(16), .SYNC(8'hA5), .TIMEOUT(16'd0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   // Reference model state, one slot per instance.
   bit         m_act  [2];
   bit         m_hl   [2];
   bit         m_rdy  [2];
   bit         m_wr   [2];
   bit         m_done [2];
   bit         m_err  [2];
   bit         m_rstc [2];
   int         m_n    [2];
   int         m_cnt  [2];
   int         m_idle [2];
   int         m_addr [2];
   logic [7:0] m_data [2];
   logic [7:0] m_pl   [2][256];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of frame parsing for instance i.
   task automatic model_step(input int i, input bit r, input bit v, input logic [7:0] d);
      int dep;
      int tmo;
      int aw;
      int s;
      dep = (i == 0) ? 256 : 16;
      tmo = (i == 0) ? 8 : 0;
      aw  = (i == 0) ? 8 : 4;
      if (r) begin
         m_act[i]  = 1'b0;
         m_hl[i]   = 1'b0;
         m_rdy[i]  = 1'b0;
         m_wr[i]   = 1'b0;
         m_done[i] = 1'b0;
         m_err[i]  = 1'b0;
         m_rstc[i] = 1'b1;
         m_idle[i] = 0;
         m_cnt[i]  = 0;
         m_addr[i] = 0;
         m_data[i] = 8'd0;
         return;
      end
      m_rstc[i] = 1'b0;
      m_wr[i]   = 1'b0;
      m_done[i] = 1'b0;
      if (v && m_rdy[i]) begin
         m_idle[i] = 0;
         if (!m_act[i]) begin
            if (d == 8'hA5) begin
               m_act[i] = 1'b1;
               m_hl[i]  = 1'b0;
               m_err[i] = 1'b0;
            end
         end else if (!m_hl[i]) begin
            m_n[i] = (d == 8'd0) ? 256 : int'(d);
            if (m_n[i] > dep) begin
               m_err[i] = 1'b1;
               m_act[i] = 1'b0;
            end else begin
               m_hl[i]  = 1'b1;
               m_cnt[i] = 0;
            end
         end else if (m_cnt[i] < m_n[i]) begin
            m_pl[i][m_cnt[i]] = d;
            m_wr[i]   = 1'b1;
            m_addr[i] = m_cnt[i] % (1 << aw);
            m_data[i] = d;
            m_cnt[i]++;
         end else begin
            s = 0;
            for (int k = 0; k < m_cnt[i]; k++) s += int'(m_pl[i][k]);
            if (d == 8'(s)) m_done[i] = 1'b1;
            else            m_err[i]  = 1'b1;
            m_act[i] = 1'b0;
         end
      end else if (m_act[i] && tmo != 0) begin
         m_idle[i]++;
         if (m_idle[i] == tmo) begin
            m_err[i]  = 1'b1;
            m_act[i]  = 1'b0;
            m_idle[i] = 0;
         end
      end
      m_rdy[i] = 1'b1;
   endtask

   task automatic compare_inst(input int i);
      logic       rdy, wr, busy, done, err;
      logic [7:0] addr, data;
      string      p;
      if (i == 0) begin
         p = "a"; rdy = ifa.rx_ready; wr = ifa.wr_en; busy = ifa.busy;
         done = ifa.done; err = ifa.err; addr = ifa.wr_addr; data = ifa.wr_data;
      end else begin
         p = "b"; rdy = ifb.rx_ready; wr = ifb.wr_en; busy = ifb.busy;
         done = ifb.done; err = ifb.err; addr = {4'd0, ifb.wr_addr}; data = ifb.wr_data;
      end
      check_eq({p, ".rx_ready"}, 32'(rdy),  32'(m_rdy[i]));
      check_eq({p, ".wr_en"},    32'(wr),   32'(m_wr[i]));
      check_eq({p, ".busy"},     32'(busy), 32'(m_act[i]));
      check_eq({p, ".done"},     32'(done), 32'(m_done[i]));
      check_eq({p, ".err"},      32'(err),  32'(m_err[i]));
      if (m_wr[i] || m_rstc[i]) begin
         check_eq({p, ".wr_addr"}, 32'(addr), 32'(m_addr[i]));
         check_eq({p, ".wr_data"}, 32'(data), 32'(m_data[i]));
      end
   endtask

   // Drive one cycle, advance the model on the edge, check 1 time unit later.
   task automatic cyc(input bit r, input bit v, input logic [7:0] d);
      @(negedge clk);
      rst = r;
      rxv = v;
      rxd = d;
      @(posedge clk);
      model_step(0, r, v, d);
      model_step(1, r, v, d);
      #1;
      compare_inst(0);
      compare_inst(1);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'($urandom_range(0, 255)));
   endtask

   // Send a byte, optionally preceded by a random gap (occasionally long
   // enough to expire instance a's timeout).
   task automatic put(input logic [7:0] b, input bit gapped);
      int g;
      g = 0;
      if (gapped) g = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 2);
      idle(g);
      cyc(1'b0, 1'b1, b);
   endtask

   initial begin
      int         len;
      int         s;
      logic [7:0] b;

      cyc(1'b1, 1'b0, 8'd0);
      cyc(1'b1, 1'b1, 8'hA5);
      idle(2);

      // Good frame, bad checksum, then good frame clearing err.
      put(8'hA5, 0); put(8'h03, 0); put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h66, 0);
      idle(2);
      put(8'hA5, 0); put(8'h02, 0); put(8'h01, 0); put(8'h02, 0); put(8'h04, 0);
      idle(2);
      put(8'hA5, 0); put(8'h01, 0); put(8'h5A, 0); put(8'h5A, 0);
      idle(2);

      // Full 256-byte frame (overflows b, whose payload bytes become noise).
      put(8'hA5, 0); put(8'h00, 0);
      for (int k = 0; k < 256; k++) put(8'(k), 0);
      put(8'h80, 0);
      idle(3);

      // Length overflow for b, then a byte that b must discard.
      put(8'hA5, 0); put(8'h20, 0); put(8'h11, 0);
      idle(12);

      // Timeout on a after one payload byte.
      put(8'hA5, 0); put(8'h02, 0); put(8'h07, 0);
      idle(8);
      idle(3);

      // Noise in idle, then reset in the middle of a 4-byte frame.
      put(8'h00, 0); put(8'hFF, 0); put(8'h5A, 0);
      put(8'hA5, 0); put(8'h04, 0); put(8'h01, 0); put(8'h02, 0);
      cyc(1'b1, 1'b1, 8'h03);
      put(8'h03, 0); put(8'h04, 0); put(8'h0A, 0);
      idle(3);

      // Randomised frames with gaps, noise and corrupted checksums.
      for (int f = 0; f < 60; f++) begin
         if ($urandom_range(0, 3) == 0) put(8'($urandom_range(0, 255)), 1);
         len = $urandom_range(1, 24);
         put(8'hA5, 1);
         put(8'(len), 1);
         s = 0;
         for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            s += int'(b);
            put(b, 1);
         end
         if ($urandom_range(0, 3) == 0) s += 1;
         put(8'(s), 1);
      end
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory loader: the write side of the PROG program store. It accepts a framed byte stream on a valid/ready input, writes the payload into the program memory write port at consecutive addresses from 0, and verifies a checksum. It holds the CPU off (`busy`) while a load is in progress. It reports completion with `done` and failure with `err`. It sits between the host byte receiver (UART RX) and the program RAM that PROG reads by `Addr`.

## Interface
Parameters:
- `ADDR_W`, 8: program memory address width.
- `DEPTH`, 256: number of writable program locations; must be ≤ 2^ADDR_W.
- `SYNC`, 8'hA5: frame start byte.
- `TIMEOUT`, 16'd50000: maximum idle cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- `clk`, in, 1: clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rx_data`, in, 8: incoming byte.
- `rx_valid`, in, 1: `rx_data` valid.
- `rx_ready`, out, 1: loader can accept a byte.
- `wr_en`, out, 1: program memory write strobe.
- `wr_addr`, out, ADDR_W: program memory write address.
- `wr_data`, out, 8: program memory write data.
- `busy`, out, 1: frame in progress; CPU must be held in reset.
- `done`, out, 1: one-cycle pulse when a frame completes with a good checksum.
- `err`, out, 1: sticky error flag.

## Operation
- Frame format: `SYNC`, `LEN`, `LEN` payload bytes, `CSUM`.
  - `LEN` = 0 encodes 256.
  - `CSUM` = sum of the payload bytes mod 256. `LEN` and `SYNC` are not included.
- A byte is accepted when `rx_valid && rx_ready`. `rx_ready` = 1 in every state except reset.
- FSM states: IDLE, LEN, DATA, CSUM.
  - IDLE: non-`SYNC` bytes are accepted and discarded. A `SYNC` byte clears `err`, sets `busy`, and moves to LEN.
  - LEN: the byte is stored as count N (0 becomes 256).
    - If N > `DEPTH`: set `err`, clear `busy`, go to IDLE.
    - Otherwise clear the index and the running sum, and go to DATA.
  - DATA: each byte is written to address = index, then the sum is updated (sum += byte, 8-bit wrap) and the index is incremented. After the Nth byte, go to CSUM.
  - CSUM: on a received byte, clear `busy` and go to IDLE.
    - If the byte equals the sum: pulse `done`.
    - If not: set `err`. Memory is not rolled back.
- A `SYNC` value received in LEN, DATA or CSUM is treated as ordinary data; there is no resynchronisation mid-frame.
- Timeout (when `TIMEOUT` ≠ 0):
  - An idle counter runs in LEN, DATA and CSUM and clears on every accepted byte.
  - When it reaches `TIMEOUT`, set `err`, clear `busy`, go to IDLE.
  - The counter is held at 0 in IDLE.
- `wr_addr` width rule: index is ADDR_W+1 bits internally, so N = 256 is counted exactly. `wr_addr` is the low ADDR_W bits.

## Timing
- Reset values:
  - `rx_ready` = 0 during the reset cycle, 1 from the first cycle after `rst` deasserts.
  - `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `busy` = 0, `done` = 0, `err` = 0.
  - FSM in IDLE, counters at 0.
- Write latency: a DATA byte accepted on edge k produces `wr_en` = 1 with `wr_addr`/`wr_data` valid for exactly the cycle following edge k. Back-to-back accepted bytes produce back-to-back write cycles.
- `busy` rises on the edge that accepts `SYNC`. It falls on the edge that accepts `CSUM`, on a `LEN` overflow, or on a timeout.
- `done` is high for exactly the one cycle following acceptance of a matching `CSUM`.
- `err` changes at the same edge as the `busy` fall. It stays set until the next accepted `SYNC` in IDLE, or reset.
- `rst` asserted mid-frame: everything returns to reset values on that edge. No further writes are issued, and memory contents already written remain.
- Timeout and an accepted byte in the same cycle: the byte wins and the counter clears.

## Test plan
- Good frame: A5 03 11 22 33 66 with `rx_valid` held high → writes (0,11), (1,22), (2,33) on consecutive cycles; `done` pulses once; `err` = 0; `busy` high from the A5 edge to the 66 edge.
- Bad checksum: A5 02 01 02 04 → two writes issued, `err` = 1, no `done`, `busy` = 0. A following good frame clears `err` on its A5.
- Full length with LEN = 00 (256 bytes, `DEPTH` = 256): addresses 0..255 written with no wrap collision; checksum of bytes 0x00..0xFF (= 0x80) accepted → `done`.
- Overflow with `DEPTH` = 16: A5 20 → `err` = 1, no `wr_en`, FSM back in IDLE. The next byte 0x11 is discarded.
- Timeout with `TIMEOUT` = 8: A5 02 07, then no `rx_valid` for 8 cycles → `err` = 1, `busy` = 0. Only (0,07) was written.
- Noise and reset: bytes 00 FF 5A in IDLE produce no writes. `rst` asserted after the 2nd payload byte of a 4-byte frame → all outputs return to reset values the next cycle, and no further writes occur.
